// File: rtl/sysarr_add_drain_if.sv
// Bus between the adder drain and its producer/consumer: adder word input, row output, stall/col status.
// With SYSARR_DRAIN_OVF_EN defined the bus also carries the sticky ovf flag and its ovf_clr input.
interface sysarr_add_drain_if #(
  parameter int DW = 16,
  parameter int N  = 4
) ();
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic          value_ready;
  logic [DW-1:0] add_output;
  logic          flush;
  // row_valid/row_ready: a row transfers on every clock edge where both are 1;
  // row_valid never waits on row_ready, and row_data is stable while row_valid holds.
  logic          row_valid;
  logic [N*DW-1:0] row_data;
  logic          row_ready;
  logic          stall;
  logic [CW-1:0] col;
`ifdef SYSARR_DRAIN_OVF_EN
  logic          ovf;
  logic          ovf_clr;

  modport master (
    output value_ready, add_output, flush, row_ready, ovf_clr,
    input  row_valid, row_data, stall, col, ovf
  );
  modport slave (
    input  value_ready, add_output, flush, row_ready, ovf_clr,
    output row_valid, row_data, stall, col, ovf
  );
`else
  modport master (
    output value_ready, add_output, flush, row_ready,
    input  row_valid, row_data, stall, col
  );
  modport slave (
    input  value_ready, add_output, flush, row_ready,
    output row_valid, row_data, stall, col
  );
`endif
endinterface

// File: rtl/sysarr_add_drain.sv
// Assembles adder result words into N-word rows and buffers them in a DEPTH-row FIFO.
// Optional sticky overflow flag under the SYSARR_DRAIN_OVF_EN macro.
module sysarr_add_drain #(
  parameter int DW    = 16,
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic nRST,
  sysarr_add_drain_if.slave bus
);
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  // The last word of a row goes straight into the FIFO, so only N-1 slots are stored.
  logic [DW-1:0]   part_q [N-1];
  logic [N*DW-1:0] mem_q  [DEPTH];
  logic [CW-1:0]   col_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;

  logic            row_done, full, pop, push, drop;
  logic [N*DW-1:0] new_row;

  always_comb begin
    row_done = bus.value_ready && (col_q == CW'(N - 1));
    full     = (count_q == CNTW'(DEPTH));
    pop      = (count_q != '0) && bus.row_ready;
    // A full FIFO still takes a row when the head leaves in the same cycle.
    push     = row_done && (!full || pop);
    drop     = row_done && full && !pop;
  end

  always_comb begin
    new_row = '0;
    for (int k = 0; k < N - 1; k++) new_row[k*DW +: DW] = part_q[k];
    new_row[(N-1)*DW +: DW] = bus.add_output;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      col_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < N - 1; k++) part_q[k] <= '0;
      for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
    end else if (bus.flush) begin
      col_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (bus.value_ready) begin
        for (int k = 0; k < N - 1; k++)
          if (col_q == CW'(k)) part_q[k] <= bus.add_output;
        col_q <= row_done ? '0 : col_q + CW'(1);
      end
      if (push) begin
        mem_q[wr_ptr_q] <= new_row;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop)
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CNTW'(1);
      else if (pop && !push) count_q <= count_q - CNTW'(1);
    end
  end

  assign bus.row_valid = (count_q != '0);
  assign bus.row_data  = mem_q[rd_ptr_q];
  assign bus.stall     = full;
  assign bus.col       = col_q;

`ifdef SYSARR_DRAIN_OVF_EN
  logic ovf_q;
  // Flush suppresses drop, so a drop here always wins over ovf_clr.
  always_ff @(posedge clk) begin
    if (!nRST || bus.flush) ovf_q <= 1'b0;
    else if (drop)          ovf_q <= 1'b1;
    else if (bus.ovf_clr)   ovf_q <= 1'b0;
  end
  assign bus.ovf = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_sysarr_add_drain.sv
// Scoreboard bench for sysarr_add_drain: directed scenarios then randomized traffic
// against a queue-based row/FIFO model.
module tb_sysarr_add_drain;
  localparam int DW    = 16;
  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(N);

  logic clk;
  logic nRST;
  sysarr_add_drain_if #(.DW(DW), .N(N)) bus ();

  sysarr_add_drain #(.DW(DW), .N(N), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [N*DW-1:0] exp_q [$];
  logic [DW-1:0]   cur_q [$];
  int              m_cnt;
  logic            m_ovf;
  int              checks;
  int              errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (nRST && !bus.flush && bus.row_valid && bus.row_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL row_unexpected: got %0h with no expected row at %0t", bus.row_data, $time);
      end else begin
        logic [N*DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.row_data !== e) begin
          errors++;
          $display("FAIL row_data: got %0h expected %0h at %0t", bus.row_data, e, $time);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_update(input logic vr, input logic [DW-1:0] w, input logic rr,
                              input logic fl, input logic rst_n, input logic oc);
    logic pop, dropped;
    logic [N*DW-1:0] row;
    dropped = 1'b0;
    if (!rst_n || fl) begin
      cur_q.delete();
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      pop = (m_cnt != 0) && rr;
      if (vr) begin
        cur_q.push_back(w);
        if (cur_q.size() == N) begin
          row = '0;
          for (int k = 0; k < N; k++) row[k*DW +: DW] = cur_q[k];
          cur_q.delete();
          if (m_cnt < DEPTH || pop) begin
            exp_q.push_back(row);
            m_cnt++;
          end else begin
            dropped = 1'b1;
            m_ovf = 1'b1;
          end
        end
      end
      if (pop) m_cnt--;
      if (oc && !dropped) m_ovf = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic vr, input logic [DW-1:0] w, input logic rr,
                      input logic fl, input logic rst_n, input logic oc);
    bus.value_ready = vr;
    bus.add_output  = w;
    bus.row_ready   = rr;
    bus.flush       = fl;
    nRST            = rst_n;
`ifdef SYSARR_DRAIN_OVF_EN
    bus.ovf_clr     = oc;
`endif
    @(posedge clk);
    model_update(vr, w, rr, fl, rst_n, oc);
    #1;
    chk("col",       64'(bus.col),       64'(cur_q.size()));
    chk("row_valid", 64'(bus.row_valid), 64'(m_cnt != 0));
    chk("stall",     64'(bus.stall),     64'(m_cnt == DEPTH));
`ifdef SYSARR_DRAIN_OVF_EN
    chk("ovf",       64'(bus.ovf),       64'(m_ovf));
`endif
  endtask

  task automatic idle(input logic rr);
    step(1'b0, '0, rr, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic word(input logic [DW-1:0] w, input logic rr);
    step(1'b1, w, rr, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic feed_row(input logic [DW-1:0] base, input logic rr);
    for (int k = 0; k < N; k++) word(base + DW'(k), rr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    nRST   = 1'b0;
    bus.value_ready = 1'b0;
    bus.add_output  = '0;
    bus.row_ready   = 1'b0;
    bus.flush       = 1'b0;
`ifdef SYSARR_DRAIN_OVF_EN
    bus.ovf_clr     = 1'b0;
`endif

    // Reset held two cycles
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_row_data", 64'(bus.row_data), 64'h0);

    // Single row with idle gaps, consumer ready
    for (int k = 1; k <= N; k++) begin
      word(DW'(k), 1'b1);
      idle(1'b1);
    end
    idle(1'b1);

    // Three rows into a two-deep FIFO with no consumer: third row dropped
    feed_row(16'h0a00, 1'b0);
    feed_row(16'h0b00, 1'b0);
    feed_row(16'h0c00, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b1);

    // Full FIFO, row completes in the same cycle as a pop
    feed_row(16'h1100, 1'b0);
    feed_row(16'h2200, 1'b0);
    for (int k = 0; k < N - 1; k++) word(16'h3300 + DW'(k), 1'b0);
    word(16'h3300 + DW'(N - 1), 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);

    // Partial row then flush
    word(16'h00ee, 1'b1);
    word(16'h00ef, 1'b1);
    step(1'b1, 16'h00f0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 5; k <= 8; k++) word(DW'(k), 1'b1);
    idle(1'b1);

    // Buffered row plus partial row, then a one-cycle reset
    feed_row(16'h4400, 1'b0);
    word(16'h5500, 1'b0);
    word(16'h5501, 1'b0);
    step(1'b1, 16'h5502, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic vr, rr, fl, rn, oc;
      vr = ($urandom_range(0, 9) < 6);
      rr = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 59) == 0);
      rn = ($urandom_range(0, 99) != 0);
      oc = ($urandom_range(0, 19) == 0);
      step(vr, DW'($urandom), rr, fl, rn, oc);
    end

    // Drain whatever is left and confirm the scoreboard empties
    for (int k = 0; k < 2 * DEPTH + 2; k++) idle(1'b1);
    chk("exp_q_empty", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
